eprom_port_arbiter: RTL and testbench
=====================================

# eprom_port_arbiter

Shares one external byte-wide program memory between the four CPU program EPROM ports of the dual-CPU subsystem: 9C and 9D (CPU 1), and 12C and 12D (CPU 2). Each port keeps a one-entry registered data latch. A port read that misses the latch becomes a pending request. A round-robin scheduler serves pending requests over a req/ack handshake to the memory. The block sits between the subsystem's EPROM abstraction buses and the board-level memory controller. It also reports any port whose data was not ready before its chip-enable window closed.

## Interface
Parameters:
- MEM_ADDR_W, 20: external memory address width; must be ≥ 17.
- MEM_BASE, 0: upper MEM_ADDR_W-17 bits of every memory address; places the ROM image.

Ports:
- CLK_48M  in  1  single system clock; all inputs are synchronous to it. CPU 6 MHz timing is derived from the same source.
- rst  in  1  reset, synchronous, active-high.
- port_addr  in  4×15  port addresses; port i occupies bits [15i+14:15i]. Port order: 0=9C, 1=9D, 2=12C, 3=12D.
- port_ce_n  in  4  combined CE/OE per port, active low.
- port_data  out  4×8  registered read data per port.
- port_late  out  4  sticky error per port: the CE window closed before the port's data was valid.
- mem_addr  out  MEM_ADDR_W  = {MEM_BASE, port index[1:0], port address[14:0]}.
- mem_rd  out  1  read request; held high until acknowledged.
- mem_ack  in  1  one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data  in  8  read data.

## Operation
- Each port i holds three registers: tag[i] (15-bit address), valid[i], data[i]. port_data[i] = data[i] at all times.
- Hit: port_ce_n[i]=0, valid[i]=1 and port_addr[i]==tag[i]. No action.
- Miss: port_ce_n[i]=0 and not a hit, and the port is neither pending nor in flight. pending[i] is set on the next clock edge.
- Scheduler states:
  - IDLE: if any pending bit is set, grant the first pending port at or after pointer rr, scanning 0→3 and wrapping. Register mem_addr from that port's current port_addr. Record the issued address. Set mem_rd=1. Clear pending for that port. Go to BUSY.
  - BUSY: mem_rd and mem_addr are held stable. On mem_ack: data[g] ← mem_data, tag[g] ← issued address, valid[g] ← 1, mem_rd ← 0, rr ← g+1 mod 4. Return to IDLE.
- mem_ack while mem_rd=0 is ignored.
- Address change while a port is in flight: the returning data is tagged with the issued (old) address. The hit check then fails and a new request is raised. No stale data is ever tagged with the new address.
- Address change while pending (not yet issued): the request is not re-raised. The grant samples port_addr at issue time.
- CE window close: port_ce_n[i] rises while pending[i]=1, or while port i is in flight, or while a miss is being detected. In that case port_late[i] is set; it is cleared only by rst.
  - A pending request is dropped.
  - An in-flight request completes and updates the latch.
- A new miss on the same cycle as mem_ack for the same port with a different address sets pending.
- Reset: mem_rd=0, mem_addr=0, port_data=0, valid=0, tag=0, pending=0, port_late=0, rr=0, state IDLE. rst during BUSY abandons the transfer; the memory controller must tolerate mem_rd dropping unacknowledged.

## Timing
- Miss sampled at cycle t → pending at t+1 → mem_rd=1 and mem_addr valid at t+2.
- Earliest mem_ack at t+2 → port_data valid at t+3. Minimum miss latency is 3 cycles.
- Back-to-back: ack at cycle a → mem_rd=0 at a+1 → next grant mem_rd=1 at a+2. There is always at least one idle cycle between requests.
- Worst case, with all four ports missing and a memory ack delay of L cycles: the last port is served after 4(L+2)+1 cycles. The integrator must keep this below the CE-low window (about 8 cycles of CLK_48M per 2H half-period), or port_late fires.

## Test plan
- After reset, all outputs are 0. Port 0 CE low at addr 0x1234, memory acks 1 cycle after mem_rd with 0xA5 → mem_addr=0x01234 at t+2, port_data[0]=0xA5 at t+4, port_late=0.
- Port 0 re-read of 0x1234 → mem_rd stays 0 (hit), and port_data[0] holds 0xA5.
- All four ports miss in the same cycle, with addresses 0x0010/0x0020/0x0030/0x0040 → grants in order 0,1,2,3. Ports are then re-triggered with new addresses (0x0011/0x0021/0x0031/0x0041) → grants in order 0,1,2,3 again, since rr has wrapped to 0. The mem_addr port fields are 0,1,2,3.
- Port 2 in flight at 0x0100; address changes to 0x0200 before the ack → the latch is tagged 0x0100, then a second request is issued for 0x0200, giving mem_addr=0x10200.
- Port 3 pending behind a stalled grant; CE rises before issue → the request is dropped and port_late[3]=1 until rst.
- rst asserted during BUSY → mem_rd=0 on the next cycle, valid is cleared, and a later ack is ignored.

Source files
------------

// File: rtl/eprom_port_arbiter.sv
// Four-port EPROM front end: per-port one-entry read latch, round-robin
// fill from a single byte-wide external memory over a req/ack handshake.
module eprom_port_arbiter #(
    parameter int          MEM_ADDR_W = 20,
    parameter int unsigned MEM_BASE   = 0
) (
    input  logic                  CLK_48M,
    input  logic                  rst,
    input  logic [3:0][14:0]      port_addr,
    input  logic [3:0]            port_ce_n,
    output logic [3:0][7:0]       port_data,
    output logic [3:0]            port_late,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data
);

    localparam logic [MEM_ADDR_W-1:0] BASE_ADDR = MEM_ADDR_W'(MEM_BASE) << 17;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [1:0]  grant;
    logic [1:0]  rr;
    logic [1:0]  sel;
    logic [1:0]  idx;
    logic [14:0] issued;
    logic [3:0]  pending;
    logic [3:0]  req;
    logic [3:0]  grant_now;
    logic [3:0]  inflight;
    logic        any_req;
    logic        fill;

    // A pending port whose CE has just risen is dropped, never granted.
    assign req     = pending & ~port_ce_n;
    assign any_req = |req;
    assign fill    = (state == BUSY) && mem_rd && mem_ack;

    always_comb begin
        sel = rr;
        idx = rr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr + 2'(k);
            if (req[idx]) sel = idx;
        end
    end

    always_comb begin
        grant_now = '0;
        inflight  = '0;
        if (state == IDLE && any_req) grant_now[sel] = 1'b1;
        if (state == BUSY) inflight[grant] = 1'b1;
    end

    always_ff @(posedge CLK_48M) begin
        if (rst) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            grant    <= '0;
            rr       <= '0;
            issued   <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant    <= sel;
                    issued   <= port_addr[sel];
                    mem_addr <= BASE_ADDR | MEM_ADDR_W'({sel, port_addr[sel]});
                    mem_rd   <= 1'b1;
                    state    <= BUSY;
                end
                BUSY: if (mem_ack) begin
                    mem_rd <= 1'b0;
                    rr     <= grant + 2'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_port
        logic [14:0] tag;
        logic [7:0]  data_q;
        logic        valid;
        logic        pend_q;
        logic        late_q;
        logic        hit;
        logic        miss;
        logic        fill_i;

        assign fill_i = fill && (grant == 2'(i));
        assign hit    = !port_ce_n[i] && valid && (port_addr[i] == tag);
        // Returning fill for an older address still counts as a miss so the
        // new address gets its own request.
        assign miss   = !port_ce_n[i] && !hit && !pend_q &&
                        (!inflight[i] || (fill_i && port_addr[i] != issued));

        assign pending[i]   = pend_q;
        assign port_late[i] = late_q;
        assign port_data[i] = data_q;

        always_ff @(posedge CLK_48M) begin
            if (rst) begin
                tag    <= '0;
                data_q <= '0;
                valid  <= 1'b0;
                pend_q <= 1'b0;
                late_q <= 1'b0;
            end else begin
                if (fill_i) begin
                    data_q <= mem_data;
                    tag    <= issued;
                    valid  <= 1'b1;
                end
                if (grant_now[i] || port_ce_n[i]) pend_q <= 1'b0;
                else if (miss)                    pend_q <= 1'b1;
                if (port_ce_n[i] && (pend_q || inflight[i])) late_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eprom_port_arbiter.sv
// Directed bench for eprom_port_arbiter: miss/hit, round-robin order,
// in-flight address change, late CE drop and reset during a transfer.
module tb_eprom_port_arbiter;

    logic             CLK_48M = 1'b0;
    logic             rst = 1'b1;
    logic [3:0][14:0] port_addr = '0;
    logic [3:0]       port_ce_n = 4'hF;
    logic [3:0][7:0]  port_data;
    logic [3:0]       port_late;
    logic [19:0]      mem_addr;
    logic             mem_rd;
    logic             mem_ack = 1'b0;
    logic [7:0]       mem_data = '0;

    int vectors = 0;
    int miscompares = 0;

    eprom_port_arbiter #(.MEM_ADDR_W(20), .MEM_BASE(0)) dut (
        .CLK_48M  (CLK_48M),
        .rst      (rst),
        .port_addr(port_addr),
        .port_ce_n(port_ce_n),
        .port_data(port_data),
        .port_late(port_late),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data)
    );

    always #5 CLK_48M = ~CLK_48M;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_48M);
        #1;
    endtask

    task automatic wait_rd();
        int n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (mem_rd !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_rd_timeout mem_rd=%b required 1", mem_rd);
        end
    endtask

    task automatic serve(input logic [7:0] d, output logic [19:0] a);
        wait_rd();
        a        = mem_addr;
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        port_ce_n = 4'hF;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        vectors++;
        if (mem_addr !== 20'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        vectors++;
        if (port_data !== 32'h0) begin miscompares++; $display("FAIL reset_port_data got %h want 0", port_data); end
        vectors++;
        if (port_late !== 4'h0) begin miscompares++; $display("FAIL reset_port_late got %b want 0", port_late); end
    endtask

    task automatic test_single_miss();
        port_addr[0] = 15'h1234;
        port_ce_n    = 4'b1110;
        tick();
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL miss_t1_rd got %b want 0", mem_rd); end
        tick();
        vectors++;
        if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL miss_t2_rd got %b want 1", mem_rd); end
        vectors++;
        if (mem_addr !== 20'h01234) begin miscompares++; $display("FAIL miss_t2_addr got %h want 01234", mem_addr); end
        tick();
        vectors++;
        if (mem_rd !== 1'b1 || port_data[0] !== 8'h00) begin
            miscompares++; $display("FAIL miss_t3_hold rd=%b data=%h want rd=1 data=00", mem_rd, port_data[0]);
        end
        mem_ack  = 1'b1;
        mem_data = 8'hA5;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        vectors++;
        if (port_data[0] !== 8'hA5) begin miscompares++; $display("FAIL miss_t4_data got %h want a5", port_data[0]); end
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL miss_t4_rd got %b want 0", mem_rd); end
        vectors++;
        if (port_late !== 4'h0) begin miscompares++; $display("FAIL miss_late got %b want 0", port_late); end
    endtask

    task automatic test_hit();
        for (int n = 0; n < 4; n++) begin
            tick();
            vectors++;
            if (mem_rd !== 1'b0 || port_data[0] !== 8'hA5) begin
                miscompares++; $display("FAIL hit_cycle%0d rd=%b data=%h want rd=0 data=a5", n, mem_rd, port_data[0]);
            end
        end
        port_ce_n = 4'hF;
        tick();
    endtask

    task automatic test_round_robin();
        logic [19:0] a;
        logic [19:0] exp;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) port_addr[k] = 15'((k + 1) * 16 + r);
            port_ce_n = 4'h0;
            for (int k = 0; k < 4; k++) begin
                serve(8'((r + 1) * 16 + k), a);
                exp = {3'b000, 2'(k), 15'((k + 1) * 16 + r)};
                vectors++;
                if (a !== exp) begin miscompares++; $display("FAIL rr_round%0d_grant%0d got %h want %h", r, k, a, exp); end
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (port_data[k] !== 8'((r + 1) * 16 + k)) begin
                    miscompares++; $display("FAIL rr_round%0d_data%0d got %h want %h", r, k, port_data[k], 8'((r + 1) * 16 + k));
                end
            end
        end
        vectors++;
        if (port_late !== 4'h0) begin miscompares++; $display("FAIL rr_late got %b want 0", port_late); end
        port_ce_n = 4'hF;
        tick();
    endtask

    task automatic test_addr_change_inflight();
        logic [19:0] a;
        port_addr[2] = 15'h0100;
        port_ce_n    = 4'b1011;
        wait_rd();
        vectors++;
        if (mem_addr !== 20'h10100) begin miscompares++; $display("FAIL chg_first_addr got %h want 10100", mem_addr); end
        port_addr[2] = 15'h0200;
        tick();
        mem_ack  = 1'b1;
        mem_data = 8'h77;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        vectors++;
        if (port_data[2] !== 8'h77) begin miscompares++; $display("FAIL chg_old_data got %h want 77", port_data[2]); end
        serve(8'h88, a);
        vectors++;
        if (a !== 20'h10200) begin miscompares++; $display("FAIL chg_second_addr got %h want 10200", a); end
        vectors++;
        if (port_data[2] !== 8'h88) begin miscompares++; $display("FAIL chg_new_data got %h want 88", port_data[2]); end
        port_ce_n = 4'hF;
        tick();
    endtask

    task automatic test_late_drop();
        port_addr[0] = 15'h0500;
        port_ce_n    = 4'b1110;
        wait_rd();
        vectors++;
        if (mem_addr !== 20'h00500) begin miscompares++; $display("FAIL late_grant0_addr got %h want 00500", mem_addr); end
        port_addr[3] = 15'h0600;
        port_ce_n    = 4'b0110;
        tick();
        tick();
        tick();
        vectors++;
        if (port_late !== 4'h0 || mem_rd !== 1'b1) begin
            miscompares++; $display("FAIL late_stall late=%b rd=%b want late=0000 rd=1", port_late, mem_rd);
        end
        port_ce_n = 4'b1110;
        tick();
        vectors++;
        if (port_late !== 4'b1000) begin miscompares++; $display("FAIL late_set got %b want 1000", port_late); end
        mem_ack  = 1'b1;
        mem_data = 8'h55;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        vectors++;
        if (port_data[0] !== 8'h55) begin miscompares++; $display("FAIL late_port0_data got %h want 55", port_data[0]); end
        for (int n = 0; n < 4; n++) tick();
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL late_dropped_rd got %b want 0", mem_rd); end
        vectors++;
        if (port_late !== 4'b1000) begin miscompares++; $display("FAIL late_sticky got %b want 1000", port_late); end
        port_ce_n = 4'hF;
        tick();
    endtask

    task automatic test_reset_busy();
        logic [19:0] a;
        port_addr[1] = 15'h0700;
        port_ce_n    = 4'b1101;
        wait_rd();
        vectors++;
        if (mem_addr !== 20'h08700) begin miscompares++; $display("FAIL rstb_addr got %h want 08700", mem_addr); end
        rst       = 1'b1;
        port_ce_n = 4'hF;
        tick();
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rstb_rd got %b want 0", mem_rd); end
        vectors++;
        if (port_late !== 4'h0) begin miscompares++; $display("FAIL rstb_late got %b want 0", port_late); end
        rst      = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        vectors++;
        if (port_data !== 32'h0 || mem_rd !== 1'b0) begin
            miscompares++; $display("FAIL rstb_stray_ack data=%h rd=%b want 0/0", port_data, mem_rd);
        end
        port_ce_n = 4'b1101;
        serve(8'h3C, a);
        vectors++;
        if (a !== 20'h08700) begin miscompares++; $display("FAIL rstb_rerequest got %h want 08700", a); end
        vectors++;
        if (port_data[1] !== 8'h3C) begin miscompares++; $display("FAIL rstb_refill got %h want 3c", port_data[1]); end
        port_ce_n = 4'hF;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_hit();
        test_round_robin();
        test_addr_change_inflight();
        test_late_drop();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
